ym3438_write_sched: RTL and testbench
=====================================

YM3438_WRITE_SCHED -- requirements
Module: ym3438_write_sched

Interface
REQ-001 Parameter HOLD_STEPS, default 24, number of c1 steps that busy stays high after a write pulse.
REQ-002 MCLK  input  1  master clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 c1  input  1  slot-step enable; the scheduler advances only on MCLK edges where c1=1.
REQ-005 fsm_cnt  input  5  slot counter {high[2:0], low[1:0]}, low in 0..2; linear slot = high*3+low (0..23).
REQ-006 wr_req  input  1  requester holds high until wr_ack or wr_err.
REQ-007 wr_bank  input  1  register bank (0: ch0-2, 1: ch3-5).
REQ-008 wr_addr  input  8  register address.
REQ-009 wr_data  input  8  register data.
REQ-010 wr_ack  output  1  one-MCLK pulse: request accepted.
REQ-011 wr_err  output  1  one-MCLK pulse: request rejected (invalid address).
REQ-012 busy  output  1  high from acceptance to end of hold.
REQ-013 slot_we  output  1  one-MCLK write strobe into the slot register file.
REQ-014 slot_we_idx  output  5  linear slot being written (0..23).
REQ-015 slot_we_addr / slot_we_data  output  8 / 8  latched address and data, valid while busy.

Function
REQ-016 States: IDLE, WAIT_SLOT, WRITE, HOLD; encoding 2 bits.
REQ-017 IDLE: on c1=1 and wr_req=1, latch bank/addr/data and decode; if valid, pulse wr_ack next cycle and go WAIT_SLOT; if invalid, pulse wr_err, no write, stay IDLE.
REQ-018 Valid address: 0x30..0x9F with addr[1:0]!=3 (operator reg), or 0xA0..0xB6 with addr[1:0]!=3 (channel reg); all others invalid.
REQ-019 Channel ch = wr_bank*3 + addr[1:0].
REQ-020 Operator reg group from addr[3:2]: 0->1, 1->2, 2->3, 3->0; target slot = group*6 + ch.
REQ-021 Channel reg target slot = ch (group 0).
REQ-022 WAIT_SLOT: on each c1=1 edge, compare linear slot of fsm_cnt with target; the acceptance edge itself is never compared.
REQ-023 On match, go WRITE: slot_we=1 for exactly one MCLK cycle with slot_we_idx=target; then HOLD.
REQ-024 fsm_cnt with low=3 never matches; the scheduler waits.
REQ-025 Worst-case latency from acceptance to slot_we: 24 c1 steps plus 1 MCLK.
REQ-026 HOLD: count HOLD_STEPS c1 steps (5-bit counter, wraps never); at terminal count go IDLE and drop busy the same cycle.
REQ-027 busy=1 in WAIT_SLOT, WRITE, HOLD; 0 in IDLE.
REQ-028 wr_req while busy is neither acked nor errored; the request stays pending.
REQ-029 A request presented on the same c1 edge busy falls is not accepted; acceptance starts the next c1 edge in IDLE.
REQ-030 Only one write is in flight; there is no queue.

Reset
REQ-031 reset_n=0 forces IDLE immediately: busy, slot_we, wr_ack, wr_err = 0; slot_we_idx, slot_we_addr, slot_we_data, hold counter = 0.
REQ-032 Reset mid-WAIT_SLOT or HOLD discards the pending write; no slot_we is issued after release.

Structure
REQ-033 Shared package: state encoding, address range bounds (0x30, 0x9F, 0xA0, 0xB6), operator group map table, slot count 24.
REQ-034 One combinational sub-module, ym3438_slot_map, maps (bank, addr) to {valid, target[4:0]}.

Verification
REQ-035 bank0 addr 0x30 data 0x5A -> wr_ack, slot_we once with idx 6, addr 0x30, data 0x5A; busy low 24 c1 steps later.
REQ-036 bank1 addr 0x3D -> target slot 4; bank0 addr 0xA1 -> slot 1; both written exactly at the fsm_cnt match.
REQ-037 addr 0x33, 0x2F, 0xB7 -> wr_err pulse, no slot_we, busy stays 0.
REQ-038 Request accepted when the current slot equals target -> slot_we after a full 24-step rotation.
REQ-039 Second wr_req held during busy -> accepted only after busy falls; reset_n pulse during WAIT_SLOT -> no slot_we, all outputs 0.

Source files
------------

// File: rtl/ym3438_write_sched_pkg.sv
// Shared definitions for the YM3438 register write scheduler: state encoding,
// register address windows, operator group map and slot arithmetic.
package ym3438_write_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SLOT = 2'd1,
    ST_WRITE     = 2'd2,
    ST_HOLD      = 2'd3
  } sched_state_e;

  localparam logic [7:0] OP_ADDR_LO = 8'h30;
  localparam logic [7:0] OP_ADDR_HI = 8'h9F;
  localparam logic [7:0] CH_ADDR_LO = 8'hA0;
  localparam logic [7:0] CH_ADDR_HI = 8'hB6;

  localparam int unsigned SLOT_COUNT = 24;

  // Operator register addr[3:2] selects the slot group (0->1, 1->2, 2->3, 3->0).
  localparam logic [1:0] OP_GROUP_MAP [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

  // Linear slot of {high[2:0], low[1:0]}; callers must reject low == 3.
  function automatic logic [4:0] linear_slot(input logic [4:0] cnt);
    return ({2'b00, cnt[4:2]} * 5'd3) + {3'b000, cnt[1:0]};
  endfunction

endpackage

// File: rtl/ym3438_slot_map.sv
// Combinational decode of (bank, register address) into a target slot and a
// validity flag for the write scheduler.
module ym3438_slot_map
  import ym3438_write_sched_pkg::*;
(
  input  logic       bank,
  input  logic [7:0] addr,
  output logic       valid,
  output logic [4:0] target
);

  logic       is_op;
  logic       is_ch;
  logic [4:0] ch;
  logic [1:0] group;

  always_comb begin
    is_op  = (addr >= OP_ADDR_LO) && (addr <= OP_ADDR_HI);
    is_ch  = (addr >= CH_ADDR_LO) && (addr <= CH_ADDR_HI);
    valid  = (is_op || is_ch) && (addr[1:0] != 2'd3);
    ch     = (bank ? 5'd3 : 5'd0) + {3'b000, addr[1:0]};
    // Channel registers always land in group 0.
    group  = is_op ? OP_GROUP_MAP[addr[3:2]] : 2'd0;
    target = ({3'b000, group} * 5'd6) + ch;
  end

endmodule

// File: rtl/ym3438_write_sched.sv
// Schedules one register write at a time into the slot register file, waiting
// for the matching slot step and then holding busy for HOLD_STEPS c1 steps.
module ym3438_write_sched
  import ym3438_write_sched_pkg::*;
#(
  parameter int unsigned HOLD_STEPS = 24
) (
  input  logic       MCLK,
  input  logic       reset_n,
  input  logic       c1,
  input  logic [4:0] fsm_cnt,
  input  logic       wr_req,
  input  logic       wr_bank,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       wr_err,
  output logic       busy,
  output logic       slot_we,
  output logic [4:0] slot_we_idx,
  output logic [7:0] slot_we_addr,
  output logic [7:0] slot_we_data
);

  localparam logic [4:0] HOLD_LAST = 5'(HOLD_STEPS - 1);

  sched_state_e state_q, state_d;
  logic [7:0]   addr_q, addr_d;
  logic [7:0]   data_q, data_d;
  logic [4:0]   target_q, target_d;
  logic [4:0]   hold_cnt_q, hold_cnt_d;
  logic         ack_q, ack_d;
  logic         err_q, err_d;

  logic         map_valid;
  logic [4:0]   map_target;
  logic [4:0]   cur_slot;
  logic         slot_match;

  ym3438_slot_map u_slot_map (
    .bank   (wr_bank),
    .addr   (wr_addr),
    .valid  (map_valid),
    .target (map_target)
  );

  always_comb begin
    cur_slot   = linear_slot(fsm_cnt);
    slot_match = (fsm_cnt[1:0] != 2'd3) && ({27'd0, cur_slot} < SLOT_COUNT)
                 && (cur_slot == target_q);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    target_d   = target_q;
    hold_cnt_d = hold_cnt_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (c1 && wr_req) begin
          addr_d = wr_addr;
          data_d = wr_data;
          if (map_valid) begin
            target_d = map_target;
            ack_d    = 1'b1;
            state_d  = ST_WAIT_SLOT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WAIT_SLOT: begin
        if (c1 && slot_match) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
      ST_HOLD: begin
        if (c1) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      target_q   <= '0;
      hold_cnt_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      target_q   <= target_d;
      hold_cnt_q <= hold_cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    wr_ack       = ack_q;
    wr_err       = err_q;
    busy         = (state_q != ST_IDLE);
    slot_we      = (state_q == ST_WRITE);
    slot_we_idx  = target_q;
    slot_we_addr = addr_q;
    slot_we_data = data_q;
  end

endmodule

// File: tb/tb_ym3438_write_sched.sv
// Bench for ym3438_write_sched: vector table of register writes checked
// against a write scoreboard, plus rotation, held-request and reset sequences.
module tb_ym3438_write_sched;

  localparam int unsigned HOLD = 24;

  logic       MCLK = 1'b0;
  logic       reset_n;
  logic       c1;
  logic [4:0] fsm_cnt;
  logic       wr_req;
  logic       wr_bank;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       wr_err;
  logic       busy;
  logic       slot_we;
  logic [4:0] slot_we_idx;
  logic [7:0] slot_we_addr;
  logic [7:0] slot_we_data;

  always #5 MCLK = ~MCLK;

  ym3438_write_sched #(.HOLD_STEPS(HOLD)) dut (
    .MCLK         (MCLK),
    .reset_n      (reset_n),
    .c1           (c1),
    .fsm_cnt      (fsm_cnt),
    .wr_req       (wr_req),
    .wr_bank      (wr_bank),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .busy         (busy),
    .slot_we      (slot_we),
    .slot_we_idx  (slot_we_idx),
    .slot_we_addr (slot_we_addr),
    .slot_we_data (slot_we_data)
  );

  typedef struct {
    logic       bank;
    logic [7:0] addr;
    logic [7:0] data;
    bit         ok;
    int         target;
  } vec_t;

  typedef struct {
    logic [4:0] idx;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  vec_t vecs [14];
  wr_t  sb [$];

  int         total = 0;
  int         bad = 0;
  int         c1_edges = 0;
  int         lin = 0;
  int         step_no = 0;
  bit         bad_en = 1'b0;
  logic       e_c1 = 1'b0;
  logic [4:0] e_fsm = '0;
  bit         we_seen = 1'b0;
  int         we_edge = 0;
  logic       prev_we = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic b, input logic [7:0] a, input logic [7:0] d,
                              input bit ok, input int t);
    vec_t v;
    v.bank = b; v.addr = a; v.data = d; v.ok = ok; v.target = t;
    return v;
  endfunction

  function automatic int edge_slot(input logic ec1, input logic [4:0] f);
    if (!ec1 || f[1:0] == 2'd3) return 99;
    return int'(f[4:2]) * 3 + int'(f[1:0]);
  endfunction

  // Slot counter advances once per c1 step; with bad_en every fourth step
  // shows the unused low=3 code instead of advancing.
  task automatic advance_fsm();
    step_no++;
    if (bad_en && (step_no % 4 == 0)) begin
      fsm_cnt = {3'(lin / 3), 2'd3};
    end else begin
      lin = (lin + 1) % 24;
      fsm_cnt = {3'(lin / 3), 2'(lin % 3)};
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    e_c1  = c1;
    e_fsm = fsm_cnt;
    if (c1) c1_edges++;
    #1;
    we_seen = 1'b0;
    if (slot_we) begin
      check("we_one_cycle", int'(prev_we), 0);
      we_seen = 1'b1;
      we_edge = c1_edges;
      if (sb.size() == 0) begin
        check("unexpected_we", 1, 0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("we_idx", int'(slot_we_idx), int'(e.idx));
        check("we_addr", int'(slot_we_addr), int'(e.addr));
        check("we_data", int'(slot_we_data), int'(e.data));
        check("we_at_match", edge_slot(e_c1, e_fsm), int'(e.idx));
      end
    end
    prev_we = slot_we;
    if (e_c1) advance_fsm();
    c1 = ~c1;
  endtask

  task automatic push_exp(input int t, input logic [7:0] a, input logic [7:0] d);
    wr_t w;
    w.idx = 5'(t); w.addr = a; w.data = d;
    sb.push_back(w);
  endtask

  task automatic wait_ack(output bit a, output bit e);
    a = 1'b0; e = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (wr_ack || wr_err) begin
        a = wr_ack; e = wr_err;
        break;
      end
    end
  endtask

  task automatic wait_write_done(input string nm);
    bit got;
    int hold_start;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      got = we_seen;
    end
    check({nm, "_we_seen"}, int'(got), 1);
    if (!got) return;
    hold_start = we_edge;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      got = !busy;
    end
    check({nm, "_idle"}, int'(got), 1);
    if (got) check({nm, "_hold_steps"}, c1_edges - hold_start, HOLD);
  endtask

  task automatic wait_slot_ahead(input int s);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = c1 && (lin == s) && (fsm_cnt[1:0] != 2'd3);
    end
  endtask

  task automatic do_write(input vec_t v, input string nm);
    bit a, e, b;
    wr_bank = v.bank; wr_addr = v.addr; wr_data = v.data; wr_req = 1'b1;
    if (v.ok) push_exp(v.target, v.addr, v.data);
    wait_ack(a, e);
    wr_req = 1'b0;
    check({nm, "_ack"}, int'(a), int'(v.ok));
    check({nm, "_err"}, int'(e), int'(!v.ok));
    check({nm, "_busy"}, int'(busy), int'(v.ok));
    tick();
    check({nm, "_pulse_len"}, int'(wr_ack | wr_err), 0);
    if (v.ok) begin
      wait_write_done(nm);
    end else begin
      b = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick();
        b |= busy;
      end
      check({nm, "_stay_idle"}, int'(b), 0);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_busy"}, int'(busy), 0);
    check({nm, "_we"}, int'(slot_we), 0);
    check({nm, "_ack"}, int'(wr_ack), 0);
    check({nm, "_err"}, int'(wr_err), 0);
    check({nm, "_idx"}, int'(slot_we_idx), 0);
    check({nm, "_addr"}, int'(slot_we_addr), 0);
    check({nm, "_data"}, int'(slot_we_data), 0);
  endtask

  initial begin
    bit a, e, got, w;
    int pulses, fall, acc;

    reset_n = 1'b0; c1 = 1'b0; fsm_cnt = '0;
    wr_req = 1'b0; wr_bank = 1'b0; wr_addr = '0; wr_data = '0;

    vecs[0]  = mk(1'b0, 8'h30, 8'h5A, 1'b1, 6);
    vecs[1]  = mk(1'b1, 8'h3D, 8'h11, 1'b1, 4);
    vecs[2]  = mk(1'b0, 8'hA1, 8'h22, 1'b1, 1);
    vecs[3]  = mk(1'b0, 8'h33, 8'h01, 1'b0, 0);
    vecs[4]  = mk(1'b0, 8'h2F, 8'h02, 1'b0, 0);
    vecs[5]  = mk(1'b0, 8'hB7, 8'h03, 1'b0, 0);
    vecs[6]  = mk(1'b1, 8'h9E, 8'h44, 1'b1, 5);
    vecs[7]  = mk(1'b1, 8'hB6, 8'h55, 1'b1, 5);
    vecs[8]  = mk(1'b0, 8'h44, 8'h66, 1'b1, 12);
    vecs[9]  = mk(1'b1, 8'h58, 8'h77, 1'b1, 21);
    vecs[10] = mk(1'b0, 8'h9F, 8'h88, 1'b0, 0);
    vecs[11] = mk(1'b1, 8'hA0, 8'h99, 1'b1, 3);
    vecs[12] = mk(1'b0, 8'hFF, 8'hAA, 1'b0, 0);
    vecs[13] = mk(1'b1, 8'h35, 8'hBB, 1'b1, 16);

    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (4) tick();

    bad_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      do_write(vecs[i], $sformatf("vec%0d", i));
    end

    // Accept exactly when the current slot equals the target.
    bad_en = 1'b0;
    wait_slot_ahead(6);
    wr_bank = 1'b0; wr_addr = 8'h30; wr_data = 8'hC3; wr_req = 1'b1;
    push_exp(6, 8'h30, 8'hC3);
    tick();
    wr_req = 1'b0;
    check("rot_ack", int'(wr_ack), 1);
    acc = c1_edges;
    wait_write_done("rot");
    check("rot_latency", we_edge - acc, 24);

    // Second request held while the first is in flight.
    wr_bank = 1'b1; wr_addr = 8'hA0; wr_data = 8'h7E; wr_req = 1'b1;
    push_exp(3, 8'hA0, 8'h7E);
    wait_ack(a, e);
    check("held_a_ack", int'(a), 1);
    wr_bank = 1'b0; wr_addr = 8'hA2; wr_data = 8'h9C; wr_req = 1'b1;
    push_exp(2, 8'hA2, 8'h9C);
    pulses = 0; got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      pulses += int'(wr_ack | wr_err);
      got = !busy;
    end
    check("held_a_idle", int'(got), 1);
    check("held_no_pulse_busy", pulses, 0);
    fall = c1_edges;
    wait_ack(a, e);
    wr_req = 1'b0;
    check("held_b_ack", int'(a), 1);
    check("held_b_accept_edge", c1_edges, fall + 1);
    wait_write_done("held_b");

    // Reset while waiting for the slot.
    wait_slot_ahead(0);
    wr_bank = 1'b1; wr_addr = 8'h58; wr_data = 8'h42; wr_req = 1'b1;
    push_exp(21, 8'h58, 8'h42);
    wait_ack(a, e);
    wr_req = 1'b0;
    check("rstw_ack", int'(a), 1);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    check_all_zero("rstw");
    sb.delete();
    tick(); tick();
    reset_n = 1'b1;
    w = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      w |= slot_we;
    end
    check("rstw_no_we", int'(w), 0);

    // Reset during hold, then a fresh write must run normally.
    wr_bank = 1'b0; wr_addr = 8'h44; wr_data = 8'h0F; wr_req = 1'b1;
    push_exp(12, 8'h44, 8'h0F);
    wait_ack(a, e);
    wr_req = 1'b0;
    check("rsth_ack", int'(a), 1);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      got = we_seen;
    end
    check("rsth_we_seen", int'(got), 1);
    repeat (6) tick();
    check("rsth_busy_before", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("rsth_busy_after", int'(busy), 0);
    tick();
    reset_n = 1'b1;
    do_write(mk(1'b1, 8'h35, 8'hE1, 1'b1, 16), "post_rst");

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
